gardner_err_sched: RTL and testbench
====================================

GARDNER_ERR_SCHED -- requirements
Module: gardner_err_sched

Interface
REQ-001 SHALL have parameter SYM_WIDTH, default 1, meaning sign-field width of each fixed-point sample.
REQ-002 SHALL have parameter INT_WIDTH, default 1, meaning integer-field width.
REQ-003 SHALL have parameter DEC_WIDTH, default 14, meaning fractional-field width.
REQ-004 SHALL define W = SYM_WIDTH+INT_WIDTH+DEC_WIDTH, and all sample and error ports SHALL be signed W-bit two's complement.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL provide the ports below, in this order:
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample triplet offered
- in_ready  out  1  block can accept a triplet
- early_I, early_Q, mid_I, mid_Q, late_I, late_Q  in  W each  Gardner strobe samples
- err  out  W  timing error
- err_sat  out  1  saturation occurred in this result
- out_valid  out  1  err and err_sat valid
- out_ready  in  1  consumer accepts err
- sat_cnt  out  8  count of saturated results
- busy  out  1  state other than IDLE

Function
REQ-007 SHALL compute err = sat(mulq(mid_I, dI) + mulq(mid_Q, dQ)), where dI = sat(late_I - early_I) and dQ = sat(late_Q - early_Q).
REQ-008 SHALL compute mulq(a,b) as the full 2W-bit signed product arithmetically shifted right by DEC_WIDTH (floor), then saturated to W bits.
REQ-009 SHALL implement sat() as clamping to [-2^(W-1), 2^(W-1)-1].
REQ-010 SHALL use exactly one W x W signed multiplier, time-shared between the I and Q products.
REQ-011 SHALL implement FSM states IDLE, DIFF, MUL_I, MUL_Q, DONE.
REQ-012 SHALL in IDLE drive in_ready=1; on in_valid&&in_ready, latch all six samples and go to DIFF.
REQ-013 SHALL in DIFF latch dI and dQ, then go to MUL_I.
REQ-014 SHALL in MUL_I latch the multiplier result mulq(mid_I,dI), then go to MUL_Q.
REQ-015 SHALL in MUL_Q form the sum with mulq(mid_Q,dQ), latch err and err_sat, then go to DONE.
REQ-016 SHALL in DONE drive out_valid=1 and hold err and err_sat stable until out_ready=1; on out_ready, go to IDLE on the same edge.
REQ-017 SHALL, with latency counted from the accepting edge E0, assert out_valid in the cycle following edge E0+3; minimum period 5 cycles per triplet.
REQ-018 SHALL keep in_ready=0 in all states except IDLE; a triplet offered while in DONE SHALL NOT be accepted until IDLE.
REQ-019 SHALL set err_sat=1 if any of the five clamps (dI, dQ, both products, final sum) saturated.
REQ-020 SHALL increment sat_cnt by 1 on each out_valid&&out_ready handshake with err_sat=1; sat_cnt SHALL stick at 255 and never wrap.
REQ-021 SHALL keep sample inputs ignored outside the accepting cycle; input changes in later cycles SHALL NOT affect the result.
REQ-022 SHALL drive busy = (state != IDLE).

Reset
REQ-023 SHALL, with rst=1 at an edge, set state=IDLE, err=0, err_sat=0, out_valid=0, sat_cnt=0, and internal registers=0 regardless of state.
REQ-024 SHALL give rst priority over all handshakes; a transaction in progress SHALL be discarded with no out_valid.
REQ-025 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Verification (W=16, DEC=14, 1.0=16384)
REQ-026 SHALL cover basic operation: early=0, late=8192, mid=8192 on I; all Q=0 -> err=4096, err_sat=0, out_valid exactly 3 edges after acceptance.
REQ-027 SHALL cover floor rounding: mid_I=1, dI=1 -> err=0; mid_I=-1, late_I=1, early_I=0 -> err=-1.
REQ-028 SHALL cover saturation: late_I=32767, early_I=-32768, mid_I=32767 -> err=32767, err_sat=1, sat_cnt increments by 1 on handshake.
REQ-029 SHALL cover backpressure: out_ready held 0 for 10 cycles -> err stable, in_ready=0 throughout, then accept next triplet after release.
REQ-030 SHALL cover reset mid-operation: rst asserted in MUL_Q -> no out_valid, next cycle IDLE, sat_cnt=0.
REQ-031 SHALL cover counter stick: 300 saturated results -> sat_cnt=255.

Source files
------------

// File: rtl/gardner_err_sched.sv
`default_nettype none
// ============================================================================
// Module      : gardner_err_sched
// Description : Gardner timing-error detector for complex samples.
//               err = sat(mulq(mid_I, dI) + mulq(mid_Q, dQ)). A single
//               W x W signed multiplier is shared between the I and Q
//               products under a five-state schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module gardner_err_sched #(
    parameter int SYM_WIDTH = 1,
    parameter int INT_WIDTH = 1,
    parameter int DEC_WIDTH = 14,
    localparam int W = SYM_WIDTH + INT_WIDTH + DEC_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] early_I,
    input  logic signed [W-1:0] early_Q,
    input  logic signed [W-1:0] mid_I,
    input  logic signed [W-1:0] mid_Q,
    input  logic signed [W-1:0] late_I,
    input  logic signed [W-1:0] late_Q,
    output logic signed [W-1:0] err,
    output logic                err_sat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          sat_cnt,
    output logic                busy
);

    localparam logic [W-1:0] c_max = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_min = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIFF  = 3'd1,
        MUL_I = 3'd2,
        MUL_Q = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Captured samples, intermediate results and outputs
    logic [W-1:0] r_early_i, r_early_q, r_mid_i, r_mid_q, r_late_i, r_late_q;
    logic [W-1:0] r_di, r_dq, r_prod_i, r_err;
    logic         r_sat_d, r_sat_p, r_err_sat;
    logic [7:0]   r_sat_cnt;

    logic w_in_ready, w_out_valid, w_accept, w_handshake;

    // Differences with saturation (one extra bit exposes overflow)
    logic [W:0]   w_di_wide, w_dq_wide;
    logic [W-1:0] w_di, w_dq;
    logic         w_di_sat, w_dq_sat;

    // Shared multiplier
    logic [W-1:0]          w_mul_a, w_mul_b;
    logic signed [2*W-1:0] w_prod, w_shift;
    logic [W:0]            w_hi;
    logic                  w_prod_sat;
    logic [W-1:0]          w_prod_q;

    // Final sum
    logic [W:0]   w_sum_wide;
    logic         w_sum_sat;
    logic [W-1:0] w_sum;

    assign w_di_wide = {r_late_i[W-1], r_late_i} - {r_early_i[W-1], r_early_i};
    assign w_dq_wide = {r_late_q[W-1], r_late_q} - {r_early_q[W-1], r_early_q};
    assign w_di_sat  = w_di_wide[W] ^ w_di_wide[W-1];
    assign w_dq_sat  = w_dq_wide[W] ^ w_dq_wide[W-1];
    assign w_di      = w_di_sat ? (w_di_wide[W] ? c_min : c_max) : w_di_wide[W-1:0];
    assign w_dq      = w_dq_sat ? (w_dq_wide[W] ? c_min : c_max) : w_dq_wide[W-1:0];

    // Operand select: Q pair only in MUL_Q, I pair otherwise
    assign w_mul_a = (r_state == MUL_Q) ? r_mid_q : r_mid_i;
    assign w_mul_b = (r_state == MUL_Q) ? r_dq    : r_di;
    assign w_prod  = $signed({{W{w_mul_a[W-1]}}, w_mul_a}) * $signed({{W{w_mul_b[W-1]}}, w_mul_b});
    // Arithmetic shift gives floor rounding of the fixed-point product
    assign w_shift = w_prod >>> DEC_WIDTH;
    // Product fits in W bits only when all bits from W-1 upward agree
    assign w_hi       = w_shift[2*W-1:W-1];
    assign w_prod_sat = !((&w_hi) || !(|w_hi));
    assign w_prod_q   = w_prod_sat ? (w_shift[2*W-1] ? c_min : c_max) : w_shift[W-1:0];

    assign w_sum_wide = {r_prod_i[W-1], r_prod_i} + {w_prod_q[W-1], w_prod_q};
    assign w_sum_sat  = w_sum_wide[W] ^ w_sum_wide[W-1];
    assign w_sum      = w_sum_sat ? (w_sum_wide[W] ? c_min : c_max) : w_sum_wide[W-1:0];

    assign w_accept    = in_valid && w_in_ready;
    assign w_handshake = w_out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next = DIFF;
            end
            DIFF:  w_next = MUL_I;
            MUL_I: w_next = MUL_Q;
            MUL_Q: w_next = DONE;
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers, each loaded only in its own schedule slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_early_i <= '0; r_early_q <= '0;
            r_mid_i   <= '0; r_mid_q   <= '0;
            r_late_i  <= '0; r_late_q  <= '0;
            r_di      <= '0; r_dq      <= '0;
            r_sat_d   <= 1'b0;
            r_prod_i  <= '0;
            r_sat_p   <= 1'b0;
            r_err     <= '0;
            r_err_sat <= 1'b0;
        end else begin
            if (w_accept) begin
                r_early_i <= early_I; r_early_q <= early_Q;
                r_mid_i   <= mid_I;   r_mid_q   <= mid_Q;
                r_late_i  <= late_I;  r_late_q  <= late_Q;
            end
            if (r_state == DIFF) begin
                r_di    <= w_di;
                r_dq    <= w_dq;
                r_sat_d <= w_di_sat | w_dq_sat;
            end
            if (r_state == MUL_I) begin
                r_prod_i <= w_prod_q;
                r_sat_p  <= w_prod_sat;
            end
            if (r_state == MUL_Q) begin
                r_err     <= w_sum;
                r_err_sat <= r_sat_d | r_sat_p | w_prod_sat | w_sum_sat;
            end
        end
    end

    // Saturation event counter, sticky at its maximum
    always_ff @(posedge clk) begin
        if (rst)
            r_sat_cnt <= 8'd0;
        else if (w_handshake && r_err_sat && (r_sat_cnt != 8'hFF))
            r_sat_cnt <= r_sat_cnt + 8'd1;
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign err       = r_err;
    assign err_sat   = r_err_sat;
    assign sat_cnt   = r_sat_cnt;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gardner_err_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gardner_err_sched
// Description : Directed self-checking bench for gardner_err_sched (W=16,
//               DEC=14, 1.0 = 16384).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gardner_err_sched;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] early_I, early_Q, mid_I, mid_Q, late_I, late_Q;
    logic signed [15:0] err;
    logic               err_sat;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         sat_cnt;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [15:0] held_err;

    gardner_err_sched #(
        .SYM_WIDTH(1),
        .INT_WIDTH(1),
        .DEC_WIDTH(14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .early_I  (early_I),
        .early_Q  (early_Q),
        .mid_I    (mid_I),
        .mid_Q    (mid_Q),
        .late_I   (late_I),
        .late_Q   (late_Q),
        .err      (err),
        .err_sat  (err_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sat_cnt  (sat_cnt),
        .busy     (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a triplet from IDLE, scramble inputs after acceptance, and check
    // that out_valid rises exactly three edges after the accepting edge.
    task automatic send(input string tag,
                        input logic [15:0] ei, input logic [15:0] li, input logic [15:0] mi,
                        input logic [15:0] eq, input logic [15:0] lq, input logic [15:0] mq);
        chk({tag, ".in_ready"}, {15'd0, in_ready}, 16'd1);
        early_I = ei; late_I = li; mid_I = mi;
        early_Q = eq; late_Q = lq; mid_Q = mq;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        early_I = 16'($urandom); late_I = 16'($urandom); mid_I = 16'($urandom);
        early_Q = 16'($urandom); late_Q = 16'($urandom); mid_Q = 16'($urandom);
        chk({tag, ".busy"}, {15'd0, busy}, 16'd1);
        chk({tag, ".ov_e1"}, {15'd0, out_valid}, 16'd0);
        step();
        chk({tag, ".ov_e2"}, {15'd0, out_valid}, 16'd0);
        step();
        chk({tag, ".ov_e3"}, {15'd0, out_valid}, 16'd0);
        step();
    endtask

    // Check the presented result, then complete the output handshake
    task automatic recv(input string tag, input logic [15:0] e_err, input logic e_sat);
        chk({tag, ".out_valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, ".err"}, err, e_err);
        chk({tag, ".err_sat"}, {15'd0, err_sat}, {15'd0, e_sat});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (e_sat && exp_cnt < 255) exp_cnt++;
        chk({tag, ".idle"}, {15'd0, busy}, 16'd0);
        chk({tag, ".sat_cnt"}, {8'd0, sat_cnt}, exp_cnt[15:0]);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        early_I = '0; early_Q = '0; mid_I = '0; mid_Q = '0; late_I = '0; late_Q = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst.err", err, 16'd0);
        chk("rst.err_sat", {15'd0, err_sat}, 16'd0);
        chk("rst.sat_cnt", {8'd0, sat_cnt}, 16'd0);
        chk("rst.busy", {15'd0, busy}, 16'd0);
        chk("rst.in_ready", {15'd0, in_ready}, 16'd1);

        // 0.5 * (0.5 - 0) = 0.25
        send("basic", 16'd0, 16'd8192, 16'd8192, 16'd0, 16'd0, 16'd0);
        recv("basic", 16'd4096, 1'b0);

        // 1 * 1 >> 14 floors to 0
        send("floor_pos", 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0);
        recv("floor_pos", 16'd0, 1'b0);

        // -1 * 1 >> 14 floors to -1
        send("floor_neg", 16'd0, 16'd1, 16'hFFFF, 16'd0, 16'd0, 16'd0);
        recv("floor_neg", 16'hFFFF, 1'b0);

        // dI saturates to 32767, product saturates to 32767
        send("sat_pos", 16'h8000, 16'd32767, 16'd32767, 16'd0, 16'd0, 16'd0);
        recv("sat_pos", 16'h7FFF, 1'b1);

        // I: 1.0*0.25 = 4096, Q: 0.5*0.5 = 4096 -> 8192
        send("iq_sum", 16'd0, 16'd4096, 16'd16384, 16'hF000, 16'd4096, 16'd8192);
        recv("iq_sum", 16'd8192, 1'b0);

        // I: 1.0*(-2.0) = -32768, Q: 1.0*(-1.0) = -16384; only the sum clamps
        send("sat_neg", 16'd16384, 16'hC000, 16'd16384, 16'd0, 16'hC000, 16'd16384);
        recv("sat_neg", 16'h8000, 1'b1);

        // Backpressure: result held, no acceptance while in DONE
        send("bp", 16'd0, 16'd8192, 16'd8192, 16'd0, 16'd0, 16'd0);
        held_err = err;
        chk("bp.first", held_err, 16'd4096);
        early_I = 16'd0; late_I = 16'd16384; mid_I = 16'd16384;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp.in_ready", {15'd0, in_ready}, 16'd0);
            chk("bp.out_valid", {15'd0, out_valid}, 16'd1);
            chk("bp.err_hold", err, 16'd4096);
            step();
        end
        in_valid = 1'b0;
        recv("bp", 16'd4096, 1'b0);
        send("bp_next", 16'd0, 16'd1, 16'hFFFF, 16'd0, 16'd0, 16'd0);
        recv("bp_next", 16'hFFFF, 1'b0);

        // Reset asserted while in MUL_Q discards the transaction
        early_I = 16'h8000; late_I = 16'd32767; mid_I = 16'd32767;
        early_Q = 16'd0; late_Q = 16'd0; mid_Q = 16'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("rstmid.busy_before", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        chk("rstmid.out_valid", {15'd0, out_valid}, 16'd0);
        chk("rstmid.busy", {15'd0, busy}, 16'd0);
        chk("rstmid.in_ready", {15'd0, in_ready}, 16'd1);
        chk("rstmid.sat_cnt", {8'd0, sat_cnt}, 16'd0);
        chk("rstmid.err", err, 16'd0);
        chk("rstmid.err_sat", {15'd0, err_sat}, 16'd0);
        step();
        chk("rstmid.out_valid2", {15'd0, out_valid}, 16'd0);

        // 300 saturated results: counter sticks at 255
        for (int i = 0; i < 300; i++) begin
            send("stick", 16'h8000, 16'd32767, 16'd32767, 16'd0, 16'd0, 16'd0);
            recv("stick", 16'h7FFF, 1'b1);
        end
        chk("stick.final", {8'd0, sat_cnt}, 16'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
